// File: rtl/reg_write_scoreboard.sv
// Register-file write-enable decoder with per-register pending-write scoreboard.
// Tracks outstanding writes with saturating counters and raises RAW/WAW issue stalls.
module reg_write_scoreboard #(
   parameter int NUM_REGS  = 32,
   parameter int ADDR_W    = 5,
   parameter int CNT_W     = 2,
   parameter int ZERO_REG  = 1,
   parameter int BYPASS_WB = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                issue_valid,
   input  logic                issue_we,
   input  logic [ADDR_W-1:0]   issue_rd,
   input  logic [ADDR_W-1:0]   issue_rs1,
   input  logic [ADDR_W-1:0]   issue_rs2,
   output logic                issue_ready,
   input  logic                wb_valid,
   input  logic [ADDR_W-1:0]   wb_rd,
   output logic [NUM_REGS-1:0] write_flag,
   output logic [NUM_REGS-1:0] busy,
   output logic                wb_underflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0]    cnt_q [NUM_REGS];
   logic [CNT_W-1:0]    cnt_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                uf_q, uf_d;
   logic                hz1, hz2, sat, iss;

   always_comb begin
      write_flag = '0;
      if (wb_valid) write_flag[wb_rd] = 1'b1;
      if (ZERO_REG != 0) write_flag[0] = 1'b0;
   end

   // A source is clear when its last pending write retires this very cycle.
   always_comb begin
      hz1 = busy_q[issue_rs1] &&
            !((BYPASS_WB != 0) && wb_valid && (wb_rd == issue_rs1) &&
              (cnt_q[issue_rs1] == CNT_ONE)) &&
            !((ZERO_REG != 0) && (issue_rs1 == '0));
      hz2 = busy_q[issue_rs2] &&
            !((BYPASS_WB != 0) && wb_valid && (wb_rd == issue_rs2) &&
              (cnt_q[issue_rs2] == CNT_ONE)) &&
            !((ZERO_REG != 0) && (issue_rs2 == '0));
      sat = issue_we && (cnt_q[issue_rd] == CNT_MAX);
      issue_ready = !(hz1 || hz2 || sat);
      iss = issue_valid && issue_ready && issue_we;
   end

   always_comb begin
      logic zr, i_hit, w_hit;
      uf_d = uf_q;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         cnt_d[r] = cnt_q[r];
         zr    = (ZERO_REG != 0) && (r == 0);
         i_hit = iss && (issue_rd == ADDR_W'(r)) && !zr;
         w_hit = wb_valid && (wb_rd == ADDR_W'(r)) && !zr;
         if (flush) begin
            cnt_d[r] = '0;
         end else if (i_hit && !w_hit) begin
            cnt_d[r] = cnt_q[r] + CNT_ONE;
         end else if (w_hit && !i_hit) begin
            if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - CNT_ONE;
            else                uf_d     = 1'b1;
         end
         busy_d[r] = (cnt_d[r] != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '{default: '0};
         busy_q <= '0;
         uf_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
         uf_q   <= uf_d;
      end
   end

   assign busy         = busy_q;
   assign wb_underflow = uf_q;

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Self-checking bench for reg_write_scoreboard: directed scenarios plus random
// traffic compared against an array-of-integers pending-write model.
module tb_reg_write_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, issue_valid, issue_we, issue_ready, wb_valid, wb_underflow;
   logic [4:0]  issue_rd, issue_rs1, issue_rs2, wb_rd;
   logic [31:0] write_flag, busy;

   int errors = 0;
   int checks = 0;
   int mcnt [32];
   bit muf;

   reg_write_scoreboard #(
      .NUM_REGS(32), .ADDR_W(5), .CNT_W(2), .ZERO_REG(1), .BYPASS_WB(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
      .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_ready(issue_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .write_flag(write_flag),
      .busy(busy), .wb_underflow(wb_underflow)
   );

   always #5 clk = ~clk;

   task automatic drive(input bit v, input bit we, input int rd, input int rs1, input int rs2,
                        input bit wv, input int wrd, input bit fl);
      issue_valid = v;  issue_we = we;  issue_rd = 5'(rd);
      issue_rs1 = 5'(rs1);  issue_rs2 = 5'(rs2);
      wb_valid = wv;  wb_rd = 5'(wrd);  flush = fl;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   function automatic bit m_stall_src(input int rs);
      if (rs == 0) return 0;
      return (mcnt[rs] > 0) && !(wb_valid && int'(wb_rd) == rs && mcnt[rs] == 1);
   endfunction

   function automatic bit m_ready();
      bit sat = issue_we && mcnt[int'(issue_rd)] == 3;
      return !(m_stall_src(int'(issue_rs1)) || m_stall_src(int'(issue_rs2)) || sat);
   endfunction

   function automatic logic [31:0] m_busy();
      logic [31:0] b = '0;
      for (int r = 0; r < 32; r++) b[r] = (mcnt[r] != 0);
      return b;
   endfunction

   function automatic logic [31:0] m_wflag();
      logic [31:0] f = '0;
      if (wb_valid && wb_rd != 0) f[wb_rd] = 1'b1;
      return f;
   endfunction

   // Advance one clock; the model consumes the inputs that were stable before the edge.
   task automatic tick();
      int  nxt [32];
      bit  acc = issue_valid && issue_we && m_ready();
      for (int r = 0; r < 32; r++) begin
         bit ih = acc && int'(issue_rd) == r && r != 0;
         bit wh = wb_valid && int'(wb_rd) == r && r != 0;
         nxt[r] = mcnt[r];
         if (flush)          nxt[r] = 0;
         else if (ih && !wh) nxt[r] = mcnt[r] + 1;
         else if (wh && !ih) begin
            if (mcnt[r] > 0) nxt[r] = mcnt[r] - 1;
            else             muf = 1;
         end
      end
      @(posedge clk);
      #1;
      mcnt = nxt;
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) mcnt[r] = 0;
      muf = 0;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      model_reset();
      #3;
      checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got=%h exp=%h", busy, 32'h0); end
      checks++; if (wb_underflow !== 1'b0) begin errors++; $display("FAIL reset_uf got=%b exp=0", wb_underflow); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
      @(negedge clk); rst_n = 1'b1;
      tick();
      // Build cnt[5]=2 and set underflow, then reset asynchronously mid-cycle.
      drive(1, 1, 5, 0, 0, 0, 0, 0); tick(); tick();
      drive(0, 0, 0, 0, 0, 1, 12, 0); tick();
      idle();
      checks++; if (busy[5] !== 1'b1 || wb_underflow !== 1'b1) begin errors++;
         $display("FAIL pre_reset got busy5=%b uf=%b exp busy5=1 uf=1", busy[5], wb_underflow); end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checks++; if (busy !== 32'h0) begin errors++; $display("FAIL async_reset_busy got=%h exp=0", busy); end
      checks++; if (wb_underflow !== 1'b0) begin errors++; $display("FAIL async_reset_uf got=%b exp=0", wb_underflow); end
      @(negedge clk); rst_n = 1'b1;
      tick();
   endtask

   task automatic test_decode();
      drive(0, 0, 0, 0, 0, 1, 7, 0); #1;
      checks++; if (write_flag !== 32'h0000_0080) begin errors++; $display("FAIL decode_7 got=%h exp=%h", write_flag, 32'h80); end
      drive(0, 0, 0, 0, 0, 0, 7, 0); #1;
      checks++; if (write_flag !== 32'h0) begin errors++; $display("FAIL decode_off got=%h exp=0", write_flag); end
      drive(0, 0, 0, 0, 0, 1, 0, 0); #1;
      checks++; if (write_flag !== 32'h0) begin errors++; $display("FAIL decode_r0 got=%h exp=0", write_flag); end
      drive(0, 0, 0, 0, 0, 1, 31, 0); #1;
      checks++; if (write_flag !== 32'h8000_0000) begin errors++; $display("FAIL decode_31 got=%h exp=%h", write_flag, 32'h8000_0000); end
      idle(); tick();
   endtask

   task automatic test_raw();
      drive(1, 1, 3, 0, 0, 0, 0, 0); tick();
      checks++; if (busy[3] !== 1'b1) begin errors++; $display("FAIL raw_busy got=%b exp=1", busy[3]); end
      drive(1, 0, 0, 3, 0, 0, 0, 0); #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got=%b exp=0", issue_ready); end
      drive(1, 0, 0, 3, 0, 1, 3, 0); #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL raw_bypass got=%b exp=1", issue_ready); end
      tick(); idle();
      checks++; if (busy[3] !== 1'b0) begin errors++; $display("FAIL raw_retired got=%b exp=0", busy[3]); end
   endtask

   task automatic test_waw();
      drive(1, 1, 9, 0, 0, 0, 0, 0); tick(); tick(); tick();
      #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL waw_sat got=%b exp=0", issue_ready); end
      tick();
      drive(0, 0, 0, 0, 0, 1, 9, 0); tick();
      drive(1, 1, 9, 0, 0, 0, 0, 0); #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL waw_release got=%b exp=1", issue_ready); end
      drive(0, 0, 0, 0, 0, 1, 9, 0); tick(); tick();
      idle(); tick();
      checks++; if (busy[9] !== 1'b0) begin errors++; $display("FAIL waw_drain got=%b exp=0", busy[9]); end
   endtask

   task automatic test_simultaneous();
      drive(1, 1, 4, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 4, 0, 0, 1, 4, 0); tick();
      idle();
      checks++; if (busy[4] !== 1'b1) begin errors++; $display("FAIL simul_busy got=%b exp=1", busy[4]); end
      drive(0, 0, 0, 0, 0, 1, 4, 0); tick();
      idle();
      checks++; if (busy[4] !== 1'b0) begin errors++; $display("FAIL simul_single got=%b exp=0", busy[4]); end
   endtask

   task automatic test_underflow_flush();
      drive(0, 0, 0, 0, 0, 1, 12, 0); tick();
      idle(); tick(); tick();
      checks++; if (wb_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got=%b exp=1", wb_underflow); end
      drive(1, 1, 2, 0, 0, 0, 0, 0); tick(); tick();
      drive(1, 1, 2, 0, 0, 1, 2, 1); #1;
      checks++; if (write_flag !== 32'h0000_0004) begin errors++; $display("FAIL flush_wflag got=%h exp=%h", write_flag, 32'h4); end
      tick(); idle();
      checks++; if (busy !== 32'h0) begin errors++; $display("FAIL flush_busy got=%h exp=0", busy); end
      checks++; if (wb_underflow !== 1'b1) begin errors++; $display("FAIL flush_keeps_uf got=%b exp=1", wb_underflow); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         bit fl = ($urandom_range(31) == 0);
         if (n == 300) begin
            rst_n = 1'b0; model_reset(); #1; rst_n = 1'b1;
         end
         drive($urandom_range(3) != 0, $urandom_range(1), $urandom_range(7),
               $urandom_range(7), $urandom_range(7),
               !fl && ($urandom_range(2) != 0), $urandom_range(7), fl);
         #1;
         checks++; if (write_flag !== m_wflag()) begin errors++;
            $display("FAIL rnd_wflag n=%0d got=%h exp=%h", n, write_flag, m_wflag()); end
         checks++; if (issue_ready !== m_ready()) begin errors++;
            $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, issue_ready, m_ready()); end
         tick();
         checks++; if (busy !== m_busy()) begin errors++;
            $display("FAIL rnd_busy n=%0d got=%h exp=%h", n, busy, m_busy()); end
         checks++; if (wb_underflow !== muf) begin errors++;
            $display("FAIL rnd_uf n=%0d got=%b exp=%b", n, wb_underflow, muf); end
      end
      idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_decode();
      test_raw();
      test_waw();
      test_simultaneous();
      test_underflow_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
